// File: rtl/mem_pkg.sv
// Shared constants for the main-memory model: word width, FSM state codes,
// operation codes and the block-alignment helper.
package mem_pkg;

   localparam int WORD_W = 32;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic OP_RD = 1'b0;
   localparam logic OP_WR = 1'b1;

   // Clears the word-offset bits so the result points at word 0 of the block.
   function automatic logic [31:0] block_base(input logic [31:0] word_addr,
                                              input int          block_words);
      return word_addr & ~(32'(block_words) - 32'd1);
   endfunction

endpackage

// File: rtl/main_mem_array.sv
// Storage array: one synchronous write port and BLOCK_WORDS combinational
// read ports addressed from a block-aligned base. Contents are never reset.
module main_mem_array
   import mem_pkg::*;
#(
   parameter int ADDR_W      = 10,
   parameter int BLOCK_WORDS = 4
) (
   input  logic                            clk,
   input  logic                            we,
   input  logic [ADDR_W-1:0]               waddr,
   input  logic [WORD_W-1:0]               wdata,
   input  logic [ADDR_W-1:0]               rbase,
   output logic [WORD_W*BLOCK_WORDS-1:0]   rblock
);

   logic [WORD_W-1:0] mem [0:(2**ADDR_W)-1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // rbase is block-aligned, so OR-ing in the word index never carries.
   for (genvar i = 0; i < BLOCK_WORDS; i++) begin : g_rd
      assign rblock[i*WORD_W +: WORD_W] = mem[rbase | ADDR_W'(i)];
   end

endmodule

// File: rtl/main_memory.sv
// Fixed-latency main-memory model serving block refills and write-through words.
// Optional `MAIN_MEM_PROTOCOL_CHECK_EN adds a sticky proto_err output.
module main_memory
   import mem_pkg::*;
#(
   parameter int ADDR_W      = 10,
   parameter int BLOCK_WORDS = 4,
   parameter int LATENCY     = 4
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            main_read,
   input  logic                            main_write,
   input  logic [ADDR_W-1:0]               addr,
   input  logic [WORD_W-1:0]               wdata,
   output logic                            ready,
   output logic [WORD_W*BLOCK_WORDS-1:0]   block_rdata,
   output logic                            busy
`ifdef MAIN_MEM_PROTOCOL_CHECK_EN
   ,
   output logic                            proto_err
`endif
);

   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

   logic [1:0]                      state;
   logic [CNT_W-1:0]                cnt;
   logic                            op_lat;
   logic [ADDR_W-1:0]               addr_lat;
   logic [WORD_W-1:0]               wdata_lat;
   logic [ADDR_W-1:0]               addr_aligned;
   logic                            req_active;
   logic                            array_we;
   logic [WORD_W*BLOCK_WORDS-1:0]   array_block;

   assign addr_aligned = ADDR_W'(block_base(32'(addr), BLOCK_WORDS));
   assign req_active   = (op_lat == OP_WR) ? main_write : main_read;
   assign array_we     = (state == ST_BUSY) && req_active && (cnt == '0) && (op_lat == OP_WR);
   assign ready        = (state == ST_RESP);
   assign busy         = (state != ST_IDLE);

   main_mem_array #(
      .ADDR_W      (ADDR_W),
      .BLOCK_WORDS (BLOCK_WORDS)
   ) u_array (
      .clk    (clk),
      .we     (array_we),
      .waddr  (addr_lat),
      .wdata  (wdata_lat),
      .rbase  (addr_lat),
      .rblock (array_block)
   );

   // A dropped request in BUSY abandons the access with no side effects.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         op_lat      <= OP_RD;
         addr_lat    <= '0;
         wdata_lat   <= '0;
         block_rdata <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (main_write) begin
                  op_lat    <= OP_WR;
                  addr_lat  <= addr;
                  wdata_lat <= wdata;
                  cnt       <= CNT_INIT;
                  state     <= ST_BUSY;
               end else if (main_read) begin
                  op_lat    <= OP_RD;
                  addr_lat  <= addr_aligned;
                  cnt       <= CNT_INIT;
                  state     <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (!req_active) begin
                  state <= ST_IDLE;
               end else if (cnt == '0) begin
                  state <= ST_RESP;
                  if (op_lat == OP_RD) begin
                     block_rdata <= array_block;
                  end
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            ST_RESP: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef MAIN_MEM_PROTOCOL_CHECK_EN
   logic addr_mismatch;

   assign addr_mismatch = (op_lat == OP_WR) ? (addr != addr_lat) : (addr_aligned != addr_lat);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         proto_err <= 1'b0;
      end else if ((main_read && main_write) ||
                   ((state == ST_BUSY) && (addr_mismatch || !req_active))) begin
         proto_err <= 1'b1;
      end
   end
`endif

endmodule

// File: doc/main_memory.md
Name: main_memory

Overview:
Multi-cycle main-memory model that sits directly downstream of the cache controller. It services the controller's main_read (block refill) and main_write (write-through word) requests. Each access takes a fixed latency, after which ready pulses for one cycle. It returns a whole cache block on reads, which the cache data array consumes on refill.

Parameters:
ADDR_W, 10, word-address width; memory depth is 2**ADDR_W 32-bit words.
BLOCK_WORDS, 4, words per cache block; power of 2, >=1.
LATENCY, 4, cycles from request acceptance to ready; >=1.

Ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  reset, asynchronous, active-low.
main_read  in  1  block read request, level-held by the requester until ready.
main_write  in  1  word write request, level-held by the requester until ready.
addr  in  ADDR_W  word address; block address = addr[ADDR_W-1:log2(BLOCK_WORDS)].
wdata  in  32  write data.
ready  out  1  one-cycle completion pulse.
block_rdata  out  32*BLOCK_WORDS  read block; word i occupies bits [32i+31:32i].
busy  out  1  high in BUSY and RESP.

Behaviour:
- States: IDLE, BUSY, RESP. 4-bit-free 2-bit encoding.
- Reset (async, any state, including mid-access):
  - state=IDLE, counter=0, ready=0, busy=0, block_rdata=0, op and address latches cleared.
  - Storage array is not reset; an access in flight is abandoned and no write occurs.
- IDLE:
  - main_write=1 → latch op=WR, addr, wdata; cnt=LATENCY-1; go to BUSY. Write has priority if both requests are high.
  - else main_read=1 → latch op=RD and the block-aligned addr; cnt=LATENCY-1; go to BUSY.
  - else stay in IDLE.
- BUSY:
  - If the latched op's request input drops, go to IDLE. No write, no ready, block_rdata unchanged (abort).
  - Else if cnt==0 → go to RESP. On the same edge:
    - WR: array[addr] <= wdata.
    - RD: block_rdata <= array[block_base+0 .. block_base+BLOCK_WORDS-1].
  - Else cnt decrements.
- RESP: ready=1 for exactly this cycle; next edge → IDLE unconditionally.
- Latency: if the accepting edge is edge 0, ready is high between edge LATENCY and edge LATENCY+1.
- Address and wdata changes after acceptance are ignored; the latched values are used.
- block_rdata is registered and holds its value until the next completed read, so the cache may refill on or after the ready cycle.
- Back-to-back accesses: a request still high in the IDLE cycle after RESP starts a new access. Minimum spacing between ready pulses is LATENCY+2 cycles.
- Read of a block containing a word written by an earlier completed write returns the new data (no forwarding needed).
- Counter width is clog2(LATENCY); LATENCY=1 means BUSY lasts one cycle.

Optional Feature:
MAIN_MEM_PROTOCOL_CHECK_EN:
- Defined: adds output proto_err (1 bit, reset 0, sticky until reset). It sets on any of:
  - main_read and main_write both high in the same cycle;
  - addr differs from the latched address while BUSY (block-aligned compare for RD);
  - the active request dropped in BUSY (abort).
- Undefined: no proto_err port. Aborts and simultaneous requests behave exactly as specified above, silently.

Decomposition:
- Package mem_pkg:
  - WORD_W=32;
  - state enum/localparams IDLE/BUSY/RESP;
  - op encoding OP_RD/OP_WR;
  - function for block base address.
- Sub-module main_mem_array (2**ADDR_W x 32): one write port, BLOCK_WORDS combinational read ports indexed from block base. The top holds the FSM, latency counter and latches.

Test Plan:
- Reset then LATENCY=4, preload array[8..11]=0xA0..0xA3, main_read=1 addr=10 at edge 0 → ready high in cycle after edge 4 only; block_rdata={0xA3,0xA2,0xA1,0xA0}; busy high edges 0–5.
- main_write=1 addr=5 wdata=0xDEADBEEF, held until ready → ready after 4 cycles; subsequent read of addr=4 returns word1=0xDEADBEEF.
- main_read and main_write both high in IDLE → write executed, read not serviced until the next access; proto_err=1 when MAIN_MEM_PROTOCOL_CHECK_EN is defined.
- main_write dropped at cycle 2 of BUSY → return to IDLE, no ready, array unchanged; proto_err=1 with the macro defined.
- reset asserted at cycle 3 of a write → immediate IDLE, ready=0, block_rdata=0, target word unchanged; after release, a fresh read completes normally.
- main_read held continuously for two responses → two ready pulses exactly LATENCY+2=6 cycles apart; LATENCY=1 build gives ready 1 cycle after acceptance.
